knn_ctrl: RTL and testbench

- Sequencer for the KNN `sorter` datapath. On `start` it latches a test point and clears the sorter.
- It then streams N training points from a 1-cycle-latency data memory into the sorter as valid-qualified (X2, Y2) pairs.
- It then asserts the sorter's DONE and walks SEL 0..K-1, emitting the K ranked sorter outputs as a result stream.
- Sits between the SoC-side register/memory interface and `sorter`; owns all sorter control pins.

---
 rtl/knn_ctrl_if.sv | 51 +++++
 rtl/knn_ctrl.sv | 138 +++++++++++++
 tb/tb_knn_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/knn_ctrl_if.sv
// Bus bundle between the KNN sequencer, the SoC side, the point memory and the sorter.
// With KNN_CTRL_PERF_EN defined the bundle also carries the 32-bit cycles counter.
interface knn_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int SEL_W  = 4,
    parameter int OUT_W  = 8
);
    logic                     start;
    logic [ADDR_W-1:0]        n_data;
    logic signed [DATA_W-1:0] test_x;
    logic signed [DATA_W-1:0] test_y;
    logic                     busy;
    logic                     done;
    logic [ADDR_W-1:0]        mem_addr;
    logic signed [DATA_W-1:0] mem_rdata_x;
    logic signed [DATA_W-1:0] mem_rdata_y;
    logic                     srt_rst;
    logic                     srt_valid;
    logic signed [DATA_W-1:0] srt_x1;
    logic signed [DATA_W-1:0] srt_y1;
    logic signed [DATA_W-1:0] srt_x2;
    logic signed [DATA_W-1:0] srt_y2;
    logic                     srt_done;
    logic [SEL_W-1:0]         srt_sel;
    logic [OUT_W-1:0]         srt_dout;
    logic                     res_valid;
    logic [SEL_W-1:0]         res_idx;
    logic [OUT_W-1:0]         res_data;
`ifdef KNN_CTRL_PERF_EN
    logic [31:0]              cycles;
`endif

    modport master (
        input  start, n_data, test_x, test_y, mem_rdata_x, mem_rdata_y, srt_dout,
        output busy, done, mem_addr, srt_rst, srt_valid, srt_x1, srt_y1, srt_x2, srt_y2,
               srt_done, srt_sel, res_valid, res_idx, res_data
`ifdef KNN_CTRL_PERF_EN
        , output cycles
`endif
    );

    modport slave (
        output start, n_data, test_x, test_y, mem_rdata_x, mem_rdata_y, srt_dout,
        input  busy, done, mem_addr, srt_rst, srt_valid, srt_x1, srt_y1, srt_x2, srt_y2,
               srt_done, srt_sel, res_valid, res_idx, res_data
`ifdef KNN_CTRL_PERF_EN
        , input cycles
`endif
    );
endinterface

// File: rtl/knn_ctrl.sv
// KNN query sequencer: clears the sorter, streams N memory points into it, reads back K ranks.
// Optional busy-cycle counter on the bus when KNN_CTRL_PERF_EN is defined.
module knn_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int K      = 10,
    parameter int SEL_W  = 4,
    parameter int OUT_W  = 8
) (
    input logic       clk,
    input logic       rst,
    knn_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_DRAIN, S_SETTLE, S_READ, S_FINISH
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(K - 1);

    state_t                   state, state_nxt;
    logic [ADDR_W-1:0]        n_q;
    logic [ADDR_W-1:0]        addr_q;
    logic signed [DATA_W-1:0] tx_q;
    logic signed [DATA_W-1:0] ty_q;
    logic                     settle_q;
    logic [SEL_W-1:0]         k_q;
    logic                     vld_p1;
    logic                     res_vld_p1;
    logic [SEL_W-1:0]         res_idx_p1;
    logic [OUT_W-1:0]         res_data_p1;
    logic                     accept, fetch_last, read_last;
    logic                     busy_c, done_c, srt_rst_c, srt_done_c;
    logic [SEL_W-1:0]         srt_sel_c;

    assign accept     = (state == S_IDLE) && bus.start;
    assign fetch_last = (addr_q == n_q - ADDR_ONE);
    assign read_last  = (k_q == SEL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // DRAIN is visited even for an empty query and SETTLE spans two cycles, so
    // every query finishes exactly n+K+5 cycles after start regardless of n.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (bus.start) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = (n_q != '0) ? S_FETCH : S_DRAIN;
            S_FETCH:  if (fetch_last) state_nxt = S_DRAIN;
            S_DRAIN:  state_nxt = S_SETTLE;
            S_SETTLE: if (settle_q) state_nxt = S_READ;
            S_READ:   if (read_last) state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_c     = (state != S_IDLE);
        done_c     = (state == S_FINISH);
        srt_rst_c  = (state == S_CLEAR);
        srt_done_c = (state == S_SETTLE) || (state == S_READ);
        srt_sel_c  = (state == S_READ) ? k_q : '0;
    end

    // Query parameters and sequencing counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q      <= '0;
            tx_q     <= '0;
            ty_q     <= '0;
            addr_q   <= '0;
            settle_q <= 1'b0;
            k_q      <= '0;
        end else begin
            if (accept) begin
                n_q  <= bus.n_data;
                tx_q <= bus.test_x;
                ty_q <= bus.test_y;
            end
            // addr_q stops at n-1, so n = 2^ADDR_W-1 never wraps.
            if (state == S_CLEAR)
                addr_q <= '0;
            else if ((state == S_FETCH) && !fetch_last)
                addr_q <= addr_q + ADDR_ONE;
            settle_q <= (state == S_SETTLE) && !settle_q;
            k_q      <= (state == S_READ) ? k_q + SEL_W'(1) : '0;
        end
    end

    // Stage p1: valid follows the issued address by the memory latency; results registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            res_vld_p1  <= 1'b0;
            res_idx_p1  <= '0;
            res_data_p1 <= '0;
        end else begin
            vld_p1     <= (state == S_FETCH);
            res_vld_p1 <= (state == S_READ);
            if (state == S_READ) begin
                res_idx_p1  <= k_q;
                res_data_p1 <= bus.srt_dout;
            end
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.mem_addr  = addr_q;
    assign bus.srt_rst   = srt_rst_c;
    assign bus.srt_valid = vld_p1;
    assign bus.srt_x1    = tx_q;
    assign bus.srt_y1    = ty_q;
    assign bus.srt_x2    = bus.mem_rdata_x;
    assign bus.srt_y2    = bus.mem_rdata_y;
    assign bus.srt_done  = srt_done_c;
    assign bus.srt_sel   = srt_sel_c;
    assign bus.res_valid = res_vld_p1;
    assign bus.res_idx   = res_idx_p1;
    assign bus.res_data  = res_data_p1;

`ifdef KNN_CTRL_PERF_EN
    logic [31:0] cycles_q;

    // Freezes on its own once the FSM is back in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         cycles_q <= '0;
        else if (accept) cycles_q <= '0;
        else if (busy_c) cycles_q <= cycles_q + 32'd1;
    end

    assign bus.cycles = cycles_q;
`endif
endmodule

// File: tb/tb_knn_ctrl.sv
// Bench for knn_ctrl: point-memory and sorter stand-ins, a cycle-window reference model
// compared every cycle, and literal expectations for latency and beat counts.
module tb_knn_ctrl;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int K      = 10;
    localparam int SEL_W  = 4;
    localparam int OUT_W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    knn_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W), .OUT_W(OUT_W)) bus();

    knn_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .K(K), .SEL_W(SEL_W), .OUT_W(OUT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    // 1-cycle-latency point memory
    logic signed [DATA_W-1:0] mem_x [256];
    logic signed [DATA_W-1:0] mem_y [256];
    always @(posedge clk) begin
        bus.mem_rdata_x <= mem_x[bus.mem_addr];
        bus.mem_rdata_y <= mem_y[bus.mem_addr];
    end

    // Sorter stand-in: rank word encodes the rank and the number of beats since its last clear.
    logic [7:0] beats;
    always @(posedge clk or posedge rst) begin
        if (rst)                beats <= 8'd0;
        else if (bus.srt_rst)   beats <= 8'd0;
        else if (bus.srt_valid) beats <= beats + 8'd1;
    end
    assign bus.srt_dout = {bus.srt_sel, 4'b0000} ^ beats;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle index since the accepted start; done lands on cycle n+K+5.
    int   cyc = 0;
    logic m_act = 1'b0;
    int   m_c = 0, m_n = 0, m_x = 0, m_y = 0, acc_cyc = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act <= 1'b0;
        end else if (!m_act) begin
            if (bus.start) begin
                m_act   <= 1'b1;
                m_c     <= 1;
                m_n     <= int'(bus.n_data);
                m_x     <= int'(bus.test_x);
                m_y     <= int'(bus.test_y);
                acc_cyc <= cyc;
            end
        end else if (m_c == m_n + K + 5) begin
            m_act <= 1'b0;
        end else begin
            m_c <= m_c + 1;
        end
    end

    int n_dones = 0, q_vld = 0, q_res = 0, q_maxaddr = 0, done_c = 0;
    int last_done_cyc = 0, last_clr_cyc = 0;

    always @(negedge clk) begin
        int c, n, d, idx;
        bit e_vld, e_sd, e_rv;
        cyc = cyc + 1;
        if (!rst) begin
            c = m_act ? m_c : 0;
            n = m_n;
            d = n + K + 5;
            if (m_act && c == 1) begin
                q_vld = 0; q_res = 0; q_maxaddr = 0;
            end
            chk("busy", int'(bus.busy), int'(m_act));
            chk("done", int'(bus.done), int'(m_act && c == d));
            chk("srt_rst", int'(bus.srt_rst), int'(m_act && c == 1));
            e_vld = m_act && c >= 3 && c <= n + 2;
            chk("srt_valid", int'(bus.srt_valid), int'(e_vld));
            if (e_vld) begin
                chk("srt_x2", int'(bus.srt_x2), int'(mem_x[c-3]));
                chk("srt_y2", int'(bus.srt_y2), int'(mem_y[c-3]));
            end
            if (m_act && c >= 2 && c <= n + 1) chk("mem_addr", int'(bus.mem_addr), c - 2);
            if (m_act && n > 0 && c == n + 2)  chk("mem_addr_hold", int'(bus.mem_addr), n - 1);
            e_sd = m_act && c >= d - K - 2 && c <= d - 1;
            chk("srt_done", int'(bus.srt_done), int'(e_sd));
            if (e_sd) chk("srt_sel", int'(bus.srt_sel), (c >= d - K) ? c - (d - K) : 0);
            if (m_act) begin
                chk("srt_x1", int'(bus.srt_x1), m_x);
                chk("srt_y1", int'(bus.srt_y1), m_y);
            end
            e_rv = m_act && c >= d - K + 1 && c <= d;
            chk("res_valid", int'(bus.res_valid), int'(e_rv));
            if (e_rv) begin
                idx = c - (d - K + 1);
                chk("res_idx", int'(bus.res_idx), idx);
                chk("res_data", int'(bus.res_data), (idx * 16) ^ (n & 255));
            end
            if (bus.srt_valid) q_vld++;
            if (bus.res_valid) q_res++;
            if (bus.busy && int'(bus.mem_addr) > q_maxaddr) q_maxaddr = int'(bus.mem_addr);
            if (bus.srt_rst) last_clr_cyc = cyc;
            if (bus.done) begin
                n_dones++;
                done_c = cyc - acc_cyc;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic run_query(input int n, input int x, input int y);
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.n_data = ADDR_W'(n);
        bus.test_x = DATA_W'(x);
        bus.test_y = DATA_W'(y);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        bit got;
        d0 = n_dones;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (n_dones != d0) begin
                got = 1'b1;
                break;
            end
        end
        chk(name, int'(got), 1);
    endtask

    initial begin
        int d1, nd;
        for (int i = 0; i < 256; i++) begin
            mem_x[i] = DATA_W'(3 * (i + 1));
            mem_y[i] = (i < 4) ? DATA_W'(3 * (i + 1)) : DATA_W'(-i);
        end
        bus.start  = 1'b0;
        bus.n_data = '0;
        bus.test_x = '0;
        bus.test_y = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_mem_addr", int'(bus.mem_addr), 0);
        chk("rst_srt_rst", int'(bus.srt_rst), 0);
        chk("rst_srt_valid", int'(bus.srt_valid), 0);
        chk("rst_srt_x1", int'(bus.srt_x1), 0);
        chk("rst_srt_y1", int'(bus.srt_y1), 0);
        chk("rst_srt_done", int'(bus.srt_done), 0);
        chk("rst_srt_sel", int'(bus.srt_sel), 0);
        chk("rst_res_valid", int'(bus.res_valid), 0);
        chk("rst_res_idx", int'(bus.res_idx), 0);
        chk("rst_res_data", int'(bus.res_data), 0);
`ifdef KNN_CTRL_PERF_EN
        chk("rst_cycles", int'(bus.cycles), 0);
`endif

        // Four points (3,3)..(12,12), test point at the origin.
        run_query(4, 0, 0);
        wait_done(200, "q4_timeout");
        chk("q4_done_cycle", done_c, 19);
        chk("q4_valid_beats", q_vld, 4);
        chk("q4_res_beats", q_res, 10);
`ifdef KNN_CTRL_PERF_EN
        @(negedge clk);
        chk("perf_after_done", int'(bus.cycles), 19);
        repeat (5) @(negedge clk);
        chk("perf_hold", int'(bus.cycles), 19);
`endif

        // Empty query: results are the cleared sorter.
        run_query(0, 5, -7);
        wait_done(200, "q0_timeout");
        chk("q0_done_cycle", done_c, 15);
        chk("q0_valid_beats", q_vld, 0);
        chk("q0_res_beats", q_res, 10);

        // start held through a whole query; inputs change mid-query.
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.n_data = ADDR_W'(2);
        bus.test_x = DATA_W'(100);
        bus.test_y = DATA_W'(-100);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        bus.n_data = ADDR_W'(7);
        bus.test_x = DATA_W'(1);
        bus.test_y = DATA_W'(2);
        wait_done(200, "hold1_timeout");
        d1 = last_done_cyc;
        chk("hold1_done_cycle", done_c, 17);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(200, "hold2_timeout");
        chk("hold2_done_cycle", done_c, 22);
        chk("hold_restart_gap", last_clr_cyc - d1, 2);

        // Full-depth memory sweep.
        run_query(255, 1, 1);
        wait_done(600, "q255_timeout");
        chk("q255_done_cycle", done_c, 270);
        chk("q255_valid_beats", q_vld, 255);
        chk("q255_max_addr", q_maxaddr, 254);
        chk("q255_res_beats", q_res, 10);

        // Reset in the middle of FETCH.
        run_query(20, 0, 0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_srt_valid", int'(bus.srt_valid), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_mem_addr", int'(bus.mem_addr), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        nd = n_dones;
        repeat (40) @(posedge clk);
        chk("abort_no_done", n_dones, nd);

        // Fresh query after the abort.
        run_query(3, -4, 9);
        wait_done(200, "q3_timeout");
        chk("q3_done_cycle", done_c, 18);
        chk("q3_valid_beats", q_vld, 3);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
